cond_wb_stage: RTL and testbench

COND_WB_STAGE -- requirements
Module: cond_wb_stage

---
 rtl/alu_pkg.sv | 22 ++
 rtl/cond_check.sv | 41 ++++
 rtl/cond_wb_stage.sv | 124 ++++++++++++
 tb/tb_cond_wb_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the conditional writeback stage: condition codes, flag
// bit positions and the output-register FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_t;

  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition-code evaluator: maps a 4-bit condition and
// the current N/Z/C/V flags to a single pass bit.
module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    pass_o = 1'b0;
    unique case (cond_t'(cond_i))
      EQ: pass_o = z;
      NE: pass_o = !z;
      CS: pass_o = c;
      CC: pass_o = !c;
      MI: pass_o = n;
      PL: pass_o = !n;
      VS: pass_o = v;
      VC: pass_o = !v;
      HI: pass_o = c && !z;
      LS: pass_o = !c || z;
      GE: pass_o = (n == v);
      LT: pass_o = (n != v);
      GT: pass_o = !z && (n == v);
      LE: pass_o = z || (n != v);
      AL: pass_o = 1'b1;
      NV: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_wb_stage.sv
// Conditional-execution writeback stage with a one-entry valid/ready output
// register and flag register. Define COND_WB_STATS_EN for exec/skip counters.
module cond_wb_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] Result,
  input  logic [3:0]       ALUFlags,
  input  logic [3:0]       Cond,
  input  logic [1:0]       FlagWrite,
  input  logic             RegWrite,
  input  logic [3:0]       WA,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] WD3,
  output logic [3:0]       A3,
  output logic             WE3,
  output logic [3:0]       Flags,
`ifdef COND_WB_STATS_EN
  output logic [7:0]       ExecCount,
  output logic [7:0]       SkipCount,
`endif
  output logic             CondEx
);

  state_t           state_q, state_d;
  logic [3:0]       flags_q, flags_d;
  logic [WIDTH-1:0] wd3_q;
  logic [3:0]       a3_q;
  logic             we3_q;
  logic             condex_q;
  logic             accept;
  logic             pass;

  // Condition sees the flags before this instruction's own update.
  cond_check u_cond_check (
    .cond_i  (Cond),
    .flags_i (flags_q),
    .pass_o  (pass)
  );

  assign InReady = (state_q == EMPTY) || OutReady;
  assign accept  = InValid && InReady;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (OutReady && !accept) state_d = EMPTY;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (accept && pass) begin
      if (FlagWrite[1]) begin
        flags_d[FLAG_N] = ALUFlags[FLAG_N];
        flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
      end
      if (FlagWrite[0]) begin
        flags_d[FLAG_C] = ALUFlags[FLAG_C];
        flags_d[FLAG_V] = ALUFlags[FLAG_V];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  // The payload is small, so it is reset too; a reset then leaves no stale
  // entry visible on WD3/A3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd3_q    <= '0;
      a3_q     <= 4'h0;
      we3_q    <= 1'b0;
      condex_q <= 1'b0;
    end else if (accept) begin
      wd3_q    <= Result;
      a3_q     <= WA;
      we3_q    <= RegWrite && pass;
      condex_q <= pass;
    end
  end

`ifdef COND_WB_STATS_EN
  logic [7:0] exec_cnt_q, skip_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_cnt_q <= 8'd0;
      skip_cnt_q <= 8'd0;
    end else if (accept) begin
      if (pass && exec_cnt_q != 8'hFF) exec_cnt_q <= exec_cnt_q + 8'd1;
      if (!pass && skip_cnt_q != 8'hFF) skip_cnt_q <= skip_cnt_q + 8'd1;
    end
  end

  assign ExecCount = exec_cnt_q;
  assign SkipCount = skip_cnt_q;
`endif

  assign OutValid = (state_q == FULL);
  assign WD3      = wd3_q;
  assign A3       = a3_q;
  assign WE3      = we3_q && OutValid;
  assign CondEx   = condex_q;
  assign Flags    = flags_q;

endmodule

// File: tb/tb_cond_wb_stage.sv
// Self-checking bench for cond_wb_stage: directed cases plus random traffic
// compared against a transaction-level model of the stage.
module tb_cond_wb_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       InValid = 1'b0;
  logic       InReady;
  logic [3:0] Result = '0;
  logic [3:0] ALUFlags = '0;
  logic [3:0] Cond = '0;
  logic [1:0] FlagWrite = '0;
  logic       RegWrite = 1'b0;
  logic [3:0] WA = '0;
  logic       OutValid;
  logic       OutReady = 1'b1;
  logic [3:0] WD3;
  logic [3:0] A3;
  logic       WE3;
  logic [3:0] Flags;
  logic       CondEx;
`ifdef COND_WB_STATS_EN
  logic [7:0] ExecCount, SkipCount;
  int         m_exec, m_skip;
`endif

  int checks = 0;
  int failures = 0;

  // Model of the stage's observable state.
  logic       m_valid;
  logic [3:0] m_wd3, m_a3, m_flags;
  logic       m_we3, m_condex;

  always #5 clk = ~clk;

  cond_wb_stage #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .InValid   (InValid),
    .InReady   (InReady),
    .Result    (Result),
    .ALUFlags  (ALUFlags),
    .Cond      (Cond),
    .FlagWrite (FlagWrite),
    .RegWrite  (RegWrite),
    .WA        (WA),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .WD3       (WD3),
    .A3        (A3),
    .WE3       (WE3),
    .Flags     (Flags),
`ifdef COND_WB_STATS_EN
    .ExecCount (ExecCount),
    .SkipCount (SkipCount),
`endif
    .CondEx    (CondEx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Conditions come in complementary pairs: odd codes invert the even base.
  function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    logic [7:0] base;
    n = f[0]; z = f[1]; cf = f[2]; v = f[3];
    base = {1'b1, !z && (n == v), n == v, cf && !z, v, n, cf, z};
    return base[c[3:1]] ^ c[0];
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".OutValid"}, OutValid, m_valid);
    check({tag, ".Flags"}, Flags, m_flags);
    check({tag, ".WE3"}, WE3, m_valid && m_we3);
    if (m_valid) begin
      check({tag, ".WD3"}, WD3, m_wd3);
      check({tag, ".A3"}, A3, m_a3);
      check({tag, ".CondEx"}, CondEx, m_condex);
    end
`ifdef COND_WB_STATS_EN
    check({tag, ".ExecCount"}, ExecCount, m_exec);
    check({tag, ".SkipCount"}, SkipCount, m_skip);
`endif
  endtask

  // Called at a negedge; drives one cycle, returns at the next negedge.
  task automatic step(input string tag, input logic iv, input logic ordy,
                      input logic [3:0] res, input logic [3:0] alf,
                      input logic [3:0] cnd, input logic [1:0] fw,
                      input logic rw, input logic [3:0] wa);
    logic rdy, acc, p;
    InValid = iv; OutReady = ordy; Result = res; ALUFlags = alf;
    Cond = cnd; FlagWrite = fw; RegWrite = rw; WA = wa;
    rdy = !m_valid || ordy;
    acc = iv && rdy;
    p = model_pass(cnd, m_flags);
    #1 check({tag, ".InReady"}, InReady, rdy);
    @(posedge clk);
    if (acc) begin
      m_valid  = 1'b1;
      m_wd3    = res;
      m_a3     = wa;
      m_we3    = rw && p;
      m_condex = p;
      if (p && fw[1]) begin m_flags[0] = alf[0]; m_flags[1] = alf[1]; end
      if (p && fw[0]) begin m_flags[2] = alf[2]; m_flags[3] = alf[3]; end
`ifdef COND_WB_STATS_EN
      if (p && m_exec < 255) m_exec++;
      if (!p && m_skip < 255) m_skip++;
`endif
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1 check_outputs(tag);
    @(negedge clk);
  endtask

  // Called at a negedge; checks that reset acts with no clock edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    InValid = 1'b0;
    m_valid = 1'b0; m_flags = 4'h0; m_we3 = 1'b0; m_condex = 1'b0;
    m_wd3 = 4'h0; m_a3 = 4'h0;
`ifdef COND_WB_STATS_EN
    m_exec = 0; m_skip = 0;
`endif
    #1;
    check_outputs(tag);
    check({tag, ".CondEx0"}, CondEx, 1'b0);
    check({tag, ".WD3_0"}, WD3, 4'h0);
    check({tag, ".A3_0"}, A3, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] snap_wd3, snap_a3;
    @(negedge clk);
    do_reset("reset");

    // Accept on the first edge after reset release; AL passes, sets Z.
    step("basic", 1, 1, 4'h5, 4'b0010, 4'hE, 2'b11, 1, 4'h3);
    check("basic.WE3_exact", WE3, 1'b1);
    check("basic.Flags_exact", Flags, 4'b0010);

    // NE fails with Z set: no write, flags untouched.
    step("ne_fail", 1, 1, 4'h9, 4'b0000, 4'h1, 2'b11, 1, 4'h7);
    check("ne_fail.WE3_exact", WE3, 1'b0);
    check("ne_fail.CondEx_exact", CondEx, 1'b0);

    // Back-to-back: op1 sets N, op2 MI sees it immediately.
    step("b2b_op1", 1, 1, 4'h1, 4'b0001, 4'hE, 2'b10, 0, 4'h2);
    step("b2b_op2", 1, 1, 4'h2, 4'b0000, 4'h4, 2'b00, 1, 4'h4);
    check("b2b_op2.WE3_exact", WE3, 1'b1);

    // Backpressure: three stalled cycles with a new request waiting.
    snap_wd3 = WD3; snap_a3 = A3;
    for (int i = 0; i < 3; i++)
      step("stall", 1, 0, 4'hC, 4'b1111, 4'hE, 2'b11, 1, 4'hD);
    check("stall.WD3_frozen", WD3, snap_wd3);
    check("stall.A3_frozen", A3, snap_a3);
    // Release: drain and reload on the same edge.
    step("release", 1, 1, 4'hC, 4'b1111, 4'hE, 2'b11, 1, 4'hD);
    check("release.WD3_exact", WD3, 4'hC);

    // Asynchronous reset while FULL.
    do_reset("midreset");

    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom), 4'($urandom));

`ifdef COND_WB_STATS_EN
    do_reset("stats_reset");
    for (int i = 0; i < 300; i++)
      step("exec_sat", 1, 1, 4'h1, 4'h0, 4'hE, 2'b00, 1, 4'h1);
    check("exec_sat.ExecCount_exact", ExecCount, 8'd255);
    for (int i = 0; i < 2; i++)
      step("skip", 1, 1, 4'h1, 4'h0, 4'hF, 2'b00, 1, 4'h1);
    check("skip.SkipCount_exact", SkipCount, 8'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
